hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_hazard_ctrl.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Pipeline hazard unit: operand forwarding selects, load-use and branch handling,
// data-memory wait stalls with deferred branch flush, timeout flag and perf counters.
module hazard_ctrl #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  rs1D,
  input  logic [4:0]  rs2D,
  input  logic [4:0]  rs1E,
  input  logic [4:0]  rs2E,
  input  logic [4:0]  RdE,
  input  logic [4:0]  RdM,
  input  logic [4:0]  RdW,
  input  logic        RegWriteM,
  input  logic        RegWriteW,
  input  logic        LoadE,
  input  logic        PCSrcE,
  input  logic        MemReqM,
  input  logic        MemReadyM,
  output logic [1:0]  Select_A,
  output logic [1:0]  Select_B,
  output logic        StallF,
  output logic        StallD,
  output logic        StallE,
  output logic        StallM,
  output logic        FlushD,
  output logic        FlushE,
  output logic        FlushW,
  output logic        MemTimeout,
  output logic [15:0] StallCount,
  output logic [15:0] FlushCount
);

  localparam int CW = $clog2(TIMEOUT + 2);

  typedef enum logic [0:0] {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic          r_pend_flush;
  logic          r_mem_timeout;
  logic [CW-1:0] r_wait_cnt;
  logic [CW-1:0] w_wait_inc;
  logic [15:0]   r_stall_cnt;
  logic [15:0]   r_flush_cnt;
  logic          w_mem_stall;
  logic          w_load_use;
  logic          w_stall_f;
  logic          w_stall_d;
  logic          w_stall_e;
  logic          w_stall_m;
  logic          w_flush_d;
  logic          w_flush_e;
  logic          w_flush_w;

  // Forwarding selects; the younger Memory-stage result wins, x0 is never forwarded
  always_comb begin
    Select_A = 2'b00;
    Select_B = 2'b00;
    if (RegWriteM && (RdM != 5'd0) && (RdM == rs1E)) begin
      Select_A = 2'b10;
    end else if (RegWriteW && (RdW != 5'd0) && (RdW == rs1E)) begin
      Select_A = 2'b01;
    end else begin
      Select_A = 2'b00;
    end
    if (RegWriteM && (RdM != 5'd0) && (RdM == rs2E)) begin
      Select_B = 2'b10;
    end else if (RegWriteW && (RdW != 5'd0) && (RdW == rs2E)) begin
      Select_B = 2'b01;
    end else begin
      Select_B = 2'b00;
    end
  end

  // Next state and same-cycle stall/flush response; memory stall dominates everything
  always_comb begin
    w_state_nxt = r_state;
    w_mem_stall = 1'b0;
    w_load_use  = LoadE && (RdE != 5'd0) && ((RdE == rs1D) || (RdE == rs2D));
    w_stall_f   = 1'b0;
    w_stall_d   = 1'b0;
    w_stall_e   = 1'b0;
    w_stall_m   = 1'b0;
    w_flush_d   = 1'b0;
    w_flush_e   = 1'b0;
    w_flush_w   = 1'b0;
    case (r_state)
      RUN: begin
        if (MemReqM && !MemReadyM) begin
          w_state_nxt = MEM_WAIT;
          w_mem_stall = 1'b1;
        end else begin
          w_state_nxt = RUN;
        end
      end
      MEM_WAIT: begin
        if (MemReadyM) begin
          w_state_nxt = RUN;
        end else begin
          w_state_nxt = MEM_WAIT;
          w_mem_stall = 1'b1;
        end
      end
      default: begin
        w_state_nxt = RUN;
      end
    endcase
    // A deferred branch flush behaves exactly like a live one; both beat load-use
    if (rst) begin
      w_stall_f = 1'b0;
    end else if (w_mem_stall) begin
      w_stall_f = 1'b1;
      w_stall_d = 1'b1;
      w_stall_e = 1'b1;
      w_stall_m = 1'b1;
      w_flush_w = 1'b1;
    end else if ((r_state == RUN) && (PCSrcE || r_pend_flush)) begin
      w_flush_d = 1'b1;
      w_flush_e = 1'b1;
    end else if ((r_state == RUN) && w_load_use) begin
      w_stall_f = 1'b1;
      w_stall_d = 1'b1;
      w_flush_e = 1'b1;
    end else begin
      w_flush_e = 1'b0;
    end
  end

  assign w_wait_inc = r_wait_cnt + {{(CW-1){1'b0}}, 1'b1};

  // State, deferred flush, wait timer, sticky timeout and saturating counters
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= RUN;
      r_pend_flush  <= 1'b0;
      r_wait_cnt    <= '0;
      r_mem_timeout <= 1'b0;
      r_stall_cnt   <= 16'd0;
      r_flush_cnt   <= 16'd0;
    end else begin
      r_state <= w_state_nxt;
      if (PCSrcE && (w_mem_stall || (r_state == MEM_WAIT))) begin
        r_pend_flush <= 1'b1;
      end else if ((r_state == RUN) && !w_mem_stall) begin
        r_pend_flush <= 1'b0;
      end else begin
        r_pend_flush <= r_pend_flush;
      end
      if ((r_state == RUN) && (w_state_nxt == MEM_WAIT)) begin
        r_wait_cnt <= '0;
      end else if ((r_state == MEM_WAIT) && (r_wait_cnt != CW'(TIMEOUT))) begin
        r_wait_cnt <= w_wait_inc;
      end else begin
        r_wait_cnt <= r_wait_cnt;
      end
      if ((r_state == MEM_WAIT) && (w_wait_inc >= CW'(TIMEOUT))) begin
        r_mem_timeout <= 1'b1;
      end else begin
        r_mem_timeout <= r_mem_timeout;
      end
      if (w_stall_f && (r_stall_cnt != 16'hFFFF)) begin
        r_stall_cnt <= r_stall_cnt + 16'd1;
      end else begin
        r_stall_cnt <= r_stall_cnt;
      end
      if (w_flush_e && (r_flush_cnt != 16'hFFFF)) begin
        r_flush_cnt <= r_flush_cnt + 16'd1;
      end else begin
        r_flush_cnt <= r_flush_cnt;
      end
    end
  end

  assign StallF     = w_stall_f;
  assign StallD     = w_stall_d;
  assign StallE     = w_stall_e;
  assign StallM     = w_stall_m;
  assign FlushD     = w_flush_d;
  assign FlushE     = w_flush_e;
  assign FlushW     = w_flush_w;
  assign MemTimeout = r_mem_timeout;
  assign StallCount = r_stall_cnt;
  assign FlushCount = r_flush_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed vectors push hand-computed responses,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_hazard_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0] rs1D, rs2D, rs1E, rs2E, RdE, RdM, RdW;
    logic RegWriteM, RegWriteW, LoadE, PCSrcE, MemReqM, MemReadyM, rst;
  } in_t;

  typedef struct {
    string       nm;
    logic [1:0]  sa, sb;
    logic [3:0]  st;
    logic [2:0]  fl;
    logic        to;
    logic [15:0] sc, fc;
    bit          ck_cnt, ck_to;
  } exp_t;

  in_t         v;
  exp_t        q[$];
  int          n_vec = 0;
  int          n_bad = 0;
  logic [15:0] m_sc, m_fc;
  logic        m_to;

  logic [1:0]  Select_A, Select_B;
  logic        StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, MemTimeout;
  logic [15:0] StallCount, FlushCount;

  hazard_ctrl #(.TIMEOUT(4)) dut (
    .clk(clk), .rst(v.rst),
    .rs1D(v.rs1D), .rs2D(v.rs2D), .rs1E(v.rs1E), .rs2E(v.rs2E),
    .RdE(v.RdE), .RdM(v.RdM), .RdW(v.RdW),
    .RegWriteM(v.RegWriteM), .RegWriteW(v.RegWriteW),
    .LoadE(v.LoadE), .PCSrcE(v.PCSrcE),
    .MemReqM(v.MemReqM), .MemReadyM(v.MemReadyM),
    .Select_A(Select_A), .Select_B(Select_B),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
    .MemTimeout(MemTimeout), .StallCount(StallCount), .FlushCount(FlushCount)
  );

  // st = {StallF,StallD,StallE,StallM}, fl = {FlushD,FlushE,FlushW}
  task automatic step(input in_t vin, input string nm, input logic [1:0] sa, input logic [1:0] sb,
                      input logic [3:0] st, input logic [2:0] fl, input bit ck_cnt, input bit ck_to);
    exp_t e;
    @(posedge clk);
    #1;
    v = vin;
    e.nm = nm; e.sa = sa; e.sb = sb; e.st = st; e.fl = fl;
    e.to = m_to; e.sc = m_sc; e.fc = m_fc; e.ck_cnt = ck_cnt; e.ck_to = ck_to;
    q.push_back(e);
    if (vin.rst) begin
      m_sc = 16'd0; m_fc = 16'd0; m_to = 1'b0;
    end else begin
      if (st[3] && (m_sc != 16'hFFFF)) m_sc = m_sc + 16'd1;
      if (fl[1] && (m_fc != 16'hFFFF)) m_fc = m_fc + 16'd1;
    end
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      bit   bad;
      e = q.pop_front();
      n_vec = n_vec + 1;
      bad = ({Select_A, Select_B} !== {e.sa, e.sb}) ||
            ({StallF, StallD, StallE, StallM} !== e.st) ||
            ({FlushD, FlushE, FlushW} !== e.fl) ||
            (e.ck_to && (MemTimeout !== e.to)) ||
            (e.ck_cnt && ((StallCount !== e.sc) || (FlushCount !== e.fc)));
      if (bad) begin
        n_bad = n_bad + 1;
        $display("FAIL %s: got sel=%b/%b stall=%b flush=%b to=%b sc=%0d fc=%0d, expected sel=%b/%b stall=%b flush=%b to=%b sc=%0d fc=%0d",
                 e.nm, Select_A, Select_B, {StallF, StallD, StallE, StallM}, {FlushD, FlushE, FlushW},
                 MemTimeout, StallCount, FlushCount, e.sa, e.sb, e.st, e.fl, e.to, e.sc, e.fc);
      end
    end
  end

  initial begin
    in_t t;
    v = '0; v.rst = 1'b1;
    m_sc = 16'd0; m_fc = 16'd0; m_to = 1'b0;
    repeat (2) @(posedge clk);

    t = '0; t.rst = 1'b1; t.rs1E = 5'd5; t.RdM = 5'd5; t.RegWriteM = 1'b1;
    step(t, "reset_state", 2'b10, 2'b00, 4'b0000, 3'b000, 1'b1, 1'b1);

    t = '0; t.rs1E = 5'd5; t.RdM = 5'd5; t.RegWriteM = 1'b1; t.RdW = 5'd5; t.RegWriteW = 1'b1;
    step(t, "fwd_mem", 2'b10, 2'b00, 4'b0000, 3'b000, 1'b1, 1'b1);
    t.RegWriteM = 1'b0;
    step(t, "fwd_wb", 2'b01, 2'b00, 4'b0000, 3'b000, 1'b0, 1'b1);
    t.RdW = 5'd0;
    step(t, "fwd_none", 2'b00, 2'b00, 4'b0000, 3'b000, 1'b0, 1'b1);
    t = '0; t.rs1E = 5'd3; t.rs2E = 5'd9; t.RdM = 5'd9; t.RegWriteM = 1'b1; t.RdW = 5'd9; t.RegWriteW = 1'b1;
    step(t, "fwd_b_prio", 2'b00, 2'b10, 4'b0000, 3'b000, 1'b0, 1'b1);
    t.RegWriteM = 1'b0;
    step(t, "fwd_b_wb", 2'b00, 2'b01, 4'b0000, 3'b000, 1'b0, 1'b1);
    t = '0; t.RegWriteM = 1'b1; t.RegWriteW = 1'b1;
    step(t, "fwd_x0", 2'b00, 2'b00, 4'b0000, 3'b000, 1'b0, 1'b1);

    t = '0; t.LoadE = 1'b1; t.RdE = 5'd7; t.rs2D = 5'd7;
    step(t, "load_use", 2'b00, 2'b00, 4'b1100, 3'b010, 1'b1, 1'b1);
    t = '0;
    step(t, "load_use_once", 2'b00, 2'b00, 4'b0000, 3'b000, 1'b1, 1'b1);
    t = '0; t.LoadE = 1'b1;
    step(t, "load_x0", 2'b00, 2'b00, 4'b0000, 3'b000, 1'b0, 1'b1);
    t = '0; t.PCSrcE = 1'b1; t.LoadE = 1'b1; t.RdE = 5'd7; t.rs1D = 5'd7;
    step(t, "branch_over_load", 2'b00, 2'b00, 4'b0000, 3'b110, 1'b0, 1'b1);
    t = '0;
    step(t, "after_branch", 2'b00, 2'b00, 4'b0000, 3'b000, 1'b1, 1'b1);

    t = '0; t.MemReqM = 1'b1;
    step(t, "mem_enter", 2'b00, 2'b00, 4'b1111, 3'b001, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) step(t, "mem_hold", 2'b00, 2'b00, 4'b1111, 3'b001, 1'b0, 1'b1);
    t.MemReadyM = 1'b1;
    step(t, "mem_ready", 2'b00, 2'b00, 4'b0000, 3'b000, 1'b0, 1'b1);
    t = '0; t.LoadE = 1'b1; t.RdE = 5'd3; t.rs1D = 5'd3;
    step(t, "run_after_mem", 2'b00, 2'b00, 4'b1100, 3'b010, 1'b1, 1'b0);
    t = '0; t.rst = 1'b1;
    step(t, "rst_mid", 2'b00, 2'b00, 4'b0000, 3'b000, 1'b0, 1'b0);

    t = '0; t.MemReqM = 1'b1;
    step(t, "dfl_enter", 2'b00, 2'b00, 4'b1111, 3'b001, 1'b1, 1'b1);
    t.PCSrcE = 1'b1;
    step(t, "dfl_branch_held", 2'b00, 2'b00, 4'b1111, 3'b001, 1'b0, 1'b1);
    t.PCSrcE = 1'b0;
    step(t, "dfl_hold", 2'b00, 2'b00, 4'b1111, 3'b001, 1'b0, 1'b1);
    t.MemReadyM = 1'b1;
    step(t, "dfl_ready", 2'b00, 2'b00, 4'b0000, 3'b000, 1'b0, 1'b1);
    t = '0;
    step(t, "dfl_first_run", 2'b00, 2'b00, 4'b0000, 3'b110, 1'b0, 1'b1);
    step(t, "dfl_once", 2'b00, 2'b00, 4'b0000, 3'b000, 1'b1, 1'b1);

    t = '0; t.MemReqM = 1'b1;
    step(t, "abort_enter", 2'b00, 2'b00, 4'b1111, 3'b001, 1'b0, 1'b1);
    t.PCSrcE = 1'b1;
    step(t, "abort_branch", 2'b00, 2'b00, 4'b1111, 3'b001, 1'b0, 1'b1);
    t = '0; t.rst = 1'b1;
    step(t, "rst_in_wait", 2'b00, 2'b00, 4'b0000, 3'b000, 1'b0, 1'b1);
    t = '0;
    step(t, "no_flush_after_rst", 2'b00, 2'b00, 4'b0000, 3'b000, 1'b1, 1'b1);

    t = '0; t.MemReqM = 1'b1;
    step(t, "to_enter", 2'b00, 2'b00, 4'b1111, 3'b001, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) step(t, "to_wait", 2'b00, 2'b00, 4'b1111, 3'b001, 1'b0, 1'b1);
    m_to = 1'b1;
    step(t, "to_set", 2'b00, 2'b00, 4'b1111, 3'b001, 1'b0, 1'b1);
    step(t, "to_sticky", 2'b00, 2'b00, 4'b1111, 3'b001, 1'b1, 1'b1);
    t = '0; t.rst = 1'b1;
    step(t, "to_rst", 2'b00, 2'b00, 4'b0000, 3'b000, 1'b0, 1'b1);
    t = '0;
    step(t, "after_to_rst", 2'b00, 2'b00, 4'b0000, 3'b000, 1'b1, 1'b1);

    for (int i = 0; i < 5; i++) begin
      if (q.size() > 0) @(negedge clk);
    end
    #1;
    if (q.size() > 0) begin
      n_bad = n_bad + 1;
      $display("FAIL drain: got %0d pending vectors, expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
